// File: rtl/cla_32bit_if.sv
// Operand/result bundle for the 32-bit carry-lookahead adder.
interface cla_32bit_if;
  localparam int unsigned W = 32;

  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         gp;
  logic         gg;

  modport master (
    output in_a, in_b, cin,
    input  sum, cout, gp, gg
  );

  modport slave (
    input  in_a, in_b, cin,
    output sum, cout, gp, gg
  );
endinterface

// File: rtl/cla_32bit.sv
// Two-level 32-bit carry-lookahead adder: 4-bit CLA blocks, 16-bit lookahead
// units, top-level carry merge, then a single registered output stage.

// 4-bit block: all internal carries from the block carry-in, no ripple.
module cla_block4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       bp,
  output logic       bg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign s  = p ^ c;
  assign bp = &p;
  assign bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
endmodule

// 16-bit unit: block carry-ins derived in parallel from block P/G.
module cla_unit16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        up,
  output logic        ug
);
  localparam int unsigned NBLK = 4;
  localparam int unsigned BW   = 4;

  logic [NBLK-1:0] bp;
  logic [NBLK-1:0] bg;
  logic [NBLK-1:0] c_blk;

  assign c_blk[0] = c_in;
  assign c_blk[1] = bg[0] | (bp[0] & c_in);
  assign c_blk[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & c_in);
  assign c_blk[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                  | (bp[2] & bp[1] & bp[0] & c_in);

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla_block4 u_blk (
      .a    (a[BW*k +: BW]),
      .b    (b[BW*k +: BW]),
      .c_in (c_blk[k]),
      .s    (s[BW*k +: BW]),
      .bp   (bp[k]),
      .bg   (bg[k])
    );
  end

  assign up = &bp;
  assign ug = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
            | (bp[3] & bp[2] & bp[1] & bg[0]);
endmodule

module cla_32bit (
  input  logic       clk,
  input  logic       rst,
  cla_32bit_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned HW = 16;

  logic [HW-1:0] s_lo;
  logic [HW-1:0] s_hi;
  logic          p_lo;
  logic          g_lo;
  logic          p_hi;
  logic          g_hi;
  logic          c_mid;
  logic [W-1:0]  sum_c;
  logic          gp_c;
  logic          gg_c;
  logic          cout_c;

  cla_unit16 u_lo (
    .a    (bus.in_a[HW-1:0]),
    .b    (bus.in_b[HW-1:0]),
    .c_in (bus.cin),
    .s    (s_lo),
    .up   (p_lo),
    .ug   (g_lo)
  );

  // Upper half carry-in comes from the low unit's group terms, not its sum.
  assign c_mid = g_lo | (p_lo & bus.cin);

  cla_unit16 u_hi (
    .a    (bus.in_a[W-1:HW]),
    .b    (bus.in_b[W-1:HW]),
    .c_in (c_mid),
    .s    (s_hi),
    .up   (p_hi),
    .ug   (g_hi)
  );

  assign sum_c  = {s_hi, s_lo};
  assign gp_c   = p_hi & p_lo;
  assign gg_c   = g_hi | (p_hi & g_lo);
  assign cout_c = gg_c | (gp_c & bus.cin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.gp   <= 1'b0;
      bus.gg   <= 1'b0;
    end else begin
      bus.sum  <= sum_c;
      bus.cout <= cout_c;
      bus.gp   <= gp_c;
      bus.gg   <= gg_c;
    end
  end
endmodule

// File: tb/tb_cla_32bit.sv
// Self-checking bench for cla_32bit: directed vectors, random holds, reset cases.
module tb_cla_32bit;
  logic clk;
  logic rst;
  cla_32bit_if bus ();

  cla_32bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_gp;
    logic        e_gg;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  int tests;
  int fails;
  int trials_clean;

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  task automatic check_model(input string nm);
    logic [32:0] full;
    logic [32:0] nocin;
    full  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {32'd0, bus.cin};
    nocin = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    check({nm, ".sum"},  {1'b0, bus.sum}, {1'b0, full[31:0]});
    check({nm, ".cout"}, {32'd0, bus.cout}, {32'd0, full[32]});
    check({nm, ".gp"},   {32'd0, bus.gp}, {32'd0, ((bus.in_a ^ bus.in_b) == 32'hFFFF_FFFF)});
    check({nm, ".gg"},   {32'd0, bus.gg}, {32'd0, nocin[32]});
    check({nm, ".excl"}, {32'd0, bus.gp & bus.gg}, 33'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".sum"},  {1'b0, bus.sum}, 33'd0);
    check({nm, ".cout"}, {32'd0, bus.cout}, 33'd0);
    check({nm, ".gp"},   {32'd0, bus.gp}, 33'd0);
    check({nm, ".gg"},   {32'd0, bus.gg}, 33'd0);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.in_a = a;
    bus.in_b = b;
    bus.cin  = c;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    trials_clean = 0;

    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};

    // Reset asserted at time zero: outputs must be clear before any edge.
    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0);
    #2;
    check_zero("rst_noedge");
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("first_after_rst");

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci);
      @(posedge clk); #1;
      check($sformatf("vec%0d.sum", i),  {1'b0, bus.sum},  {1'b0, tbl[i].e_sum});
      check($sformatf("vec%0d.cout", i), {32'd0, bus.cout}, {32'd0, tbl[i].e_cout});
      check($sformatf("vec%0d.gp", i),   {32'd0, bus.gp},   {32'd0, tbl[i].e_gp});
      check($sformatf("vec%0d.gg", i),   {32'd0, bus.gg},   {32'd0, tbl[i].e_gg});
    end

    // One-cycle latency: new inputs must not appear before the edge.
    drive(32'h0000_0001, 32'h0000_0002, 1'b0);
    #2;
    check("latency_hold", {1'b0, bus.sum}, {1'b0, tbl[NVEC-1].e_sum});
    @(posedge clk); #1;
    check("latency_load", {1'b0, bus.sum}, 33'd3);

    // Random holds of 8 cycles each.
    for (int t = 0; t < 12; t++) begin
      int f0;
      f0 = fails;
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        check_model($sformatf("hold%0d_%0d", t, c));
      end
      if (fails == f0) trials_clean++;
    end
    $display("[TB] random hold trials clean: %0d of 12", trials_clean);

    // Inputs changing every cycle.
    for (int k = 0; k < 40; k++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      check_model($sformatf("stream%0d", k));
    end

    // Mid-stream reset pulse with nonzero inputs.
    drive(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    @(posedge clk); #1;
    check_model("pre_rst");
    #1;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk); #1;
    check_zero("rst_held");
    rst = 1'b0;
    #1;
    check_zero("rst_released_noedge");
    @(posedge clk); #1;
    check_model("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_32bit.md
Name: cla_32bit

Overview:
32-bit two-level carry-lookahead adder. It computes in_a + in_b + cin and exports block-level group propagate and generate signals, so it can be cascaded into wider lookahead trees. The arithmetic core is combinational. All outputs are captured in a single output register stage clocked by clk.

Parameters:
None. The width is fixed at 32 bits.

Ports:
clk    input   1   clock; output register updates on rising edge
rst    input   1   reset, asynchronous, active-high; clears output registers
in_a   input   32  addend A, unsigned
in_b   input   32  addend B, unsigned
cin    input   1   carry in to bit 0
sum    output  32  registered (in_a + in_b + cin)[31:0]
cout   output  1   registered carry out of bit 31
gp     output  1   registered group propagate: all 32 bit-propagates true
gg     output  1   registered group generate: carry out of bit 31 when cin = 0

Behaviour:
- Bit level, for i = 0..31:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
  - s_i = p_i ^ c_i
- Level 1: eight 4-bit CLA blocks.
  - Each block computes its internal carries from its own carry-in using lookahead equations; no ripple inside a block.
  - Each block outputs block P = p3&p2&p1&p0.
  - Each block outputs block G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Level 2: two 16-bit lookahead units, each spanning four blocks.
  - Each unit derives the carry-ins of its four blocks in parallel from block P/G and the unit carry-in.
  - Each unit produces a unit P and a unit G using the same equations.
- Top:
  - Carry into bits 16..31 = G_lo | (P_lo & cin).
  - gp_comb = P_hi & P_lo.
  - gg_comb = G_hi | (P_hi & G_lo).
  - cout_comb = gg_comb | (gp_comb & cin).
- No ripple path longer than one 4-bit block is allowed; carries must come from the lookahead equations.
- {cout_comb, sum_comb} must equal the 33-bit value in_a + in_b + cin for every input combination.
- Output register:
  - On posedge clk with rst low, sum/cout/gp/gg load the combinational results.
  - Latency is exactly 1 cycle: a result is valid on the first rising edge after its inputs settle.
  - With constant inputs, outputs hold constant.
- Reset:
  - rst high immediately forces sum = 0, cout = 0, gp = 0, gg = 0, independent of clk.
  - Outputs stay 0 while rst is high.
  - On the first rising edge after rst falls, the outputs load the current inputs.
  - A reset asserted mid-operation discards the pending result. No other state exists.
- Wrap-around: a sum of 2^32 or more wraps in sum, with cout = 1. The maximum case 0xFFFFFFFF + 0xFFFFFFFF + 1 gives sum = 0xFFFFFFFF, cout = 1.
- gp and gg do not depend on cin. gp and gg are never both 1, since p_i and g_i are mutually exclusive per bit.
- Inputs may change every cycle; each registered output reflects the inputs present at that edge.

Test Plan:
- Reset, then in_a = 0, in_b = 0, cin = 0, one clock -> sum = 0, cout = 0, gp = 0, gg = 0. While rst is high, outputs are 0 with no clock edge.
- in_a = 0xFFFFFFFF, in_b = 0, cin = 1 -> sum = 0x00000000, cout = 1, gp = 1, gg = 0. With cin = 0 -> sum = 0xFFFFFFFF, cout = 0.
- in_a = 0x80000000, in_b = 0x80000000, cin = 0 -> sum = 0, cout = 1, gp = 0, gg = 1.
- Cross-boundary carry: in_a = 0x0000FFFF, in_b = 0x00000001, cin = 0 -> sum = 0x00010000, cout = 0. Also in_a = 0x0000000F, in_b = 0x00000001 -> sum = 0x00000010.
- Randomised: reset, then apply random in_a/in_b/cin and hold for 8 cycles -> {cout, sum} == in_a + in_b + cin (33-bit) on every cycle after the first. Run at least 10 trials with a pass count.
- Pulse rst for one cycle mid-stream with nonzero inputs -> outputs go to 0 immediately and return to the correct sum one clock after rst deasserts.
